// File: rtl/nwr_arbiter_if.sv
// Bundle of requester, initiator-status and initiator-payload signals around nwr_arbiter.
// master: the arbiter side; slave: requesters plus NWRITE initiator.
interface nwr_arbiter_if;
    logic        req0_i;
    logic [33:0] req0_addr_i;
    logic [11:0] req0_tsize_i;
    logic [63:0] req0_tdata_i;
    logic [7:0]  req0_tkeep_i;
    logic        req0_tvalid_i;
    logic        req0_tlast_i;
    logic        req0_tready_o;
    logic        req0_done_o;
    logic        req0_err_o;

    logic        req1_i;
    logic [33:0] req1_addr_i;
    logic [11:0] req1_tsize_i;
    logic [63:0] req1_tdata_i;
    logic [7:0]  req1_tkeep_i;
    logic        req1_tvalid_i;
    logic        req1_tlast_i;
    logic        req1_tready_o;
    logic        req1_done_o;
    logic        req1_err_o;

    logic        nwr_ready_in;
    logic        nwr_busy_in;
    logic        nwr_done_in;
    logic        user_tready_in;
    logic [33:0] user_addr_o;
    logic [11:0] user_tsize_o;
    logic [63:0] user_tdata_o;
    logic [7:0]  user_tkeep_o;
    logic        user_tvalid_o;
    logic        user_tlast_o;

    modport master (
        input  req0_i, req0_addr_i, req0_tsize_i, req0_tdata_i, req0_tkeep_i,
               req0_tvalid_i, req0_tlast_i,
        input  req1_i, req1_addr_i, req1_tsize_i, req1_tdata_i, req1_tkeep_i,
               req1_tvalid_i, req1_tlast_i,
        input  nwr_ready_in, nwr_busy_in, nwr_done_in, user_tready_in,
        output req0_tready_o, req0_done_o, req0_err_o,
        output req1_tready_o, req1_done_o, req1_err_o,
        output user_addr_o, user_tsize_o, user_tdata_o, user_tkeep_o,
               user_tvalid_o, user_tlast_o
    );

    modport slave (
        output req0_i, req0_addr_i, req0_tsize_i, req0_tdata_i, req0_tkeep_i,
               req0_tvalid_i, req0_tlast_i,
        output req1_i, req1_addr_i, req1_tsize_i, req1_tdata_i, req1_tkeep_i,
               req1_tvalid_i, req1_tlast_i,
        output nwr_ready_in, nwr_busy_in, nwr_done_in, user_tready_in,
        input  req0_tready_o, req0_done_o, req0_err_o,
        input  req1_tready_o, req1_done_o, req1_err_o,
        input  user_addr_o, user_tsize_o, user_tdata_o, user_tkeep_o,
               user_tvalid_o, user_tlast_o
    );
endinterface

// File: rtl/nwr_arbiter.sv
// Round-robin arbiter granting one of two NWRITE requesters to a single initiator.
// Define NWR_ARB_TIMEOUT_EN to abort WAIT_DONE after TIMEOUT_CYC cycles with an err pulse.
module nwr_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic          log_clk,
    input  logic          log_rst,
    nwr_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT     = 2'd1,
        XFER      = 2'd2,
        WAIT_DONE = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        last_q, last_d;
    logic        gnt_q, gnt_d;
    logic [33:0] user_addr_q, user_addr_d;
    logic [11:0] user_tsize_q, user_tsize_d;
    logic [1:0]  done_q, done_d;
    logic [8:0]  beat_cnt_q, beat_cnt_d;

    logic in_xfer;
    logic sel_tvalid;
    logic sel_tlast;
    logic beat_acc;
    logic win;

    assign in_xfer    = (state_q == XFER);
    assign sel_tvalid = gnt_q ? bus.req1_tvalid_i : bus.req0_tvalid_i;
    assign sel_tlast  = gnt_q ? bus.req1_tlast_i  : bus.req0_tlast_i;
    assign beat_acc   = in_xfer & sel_tvalid & bus.user_tready_in;
    // On a tie the requester not granted last wins; a lone request wins outright.
    assign win = (bus.req0_i & bus.req1_i) ? ~last_q : bus.req1_i;

    assign bus.user_tdata_o  = gnt_q ? bus.req1_tdata_i : bus.req0_tdata_i;
    assign bus.user_tkeep_o  = gnt_q ? bus.req1_tkeep_i : bus.req0_tkeep_i;
    assign bus.user_tvalid_o = in_xfer & sel_tvalid;
    assign bus.user_tlast_o  = in_xfer & sel_tlast;
    assign bus.req0_tready_o = in_xfer & ~gnt_q & bus.user_tready_in;
    assign bus.req1_tready_o = in_xfer &  gnt_q & bus.user_tready_in;
    assign bus.user_addr_o   = user_addr_q;
    assign bus.user_tsize_o  = user_tsize_q;
    assign bus.req0_done_o   = done_q[0];
    assign bus.req1_done_o   = done_q[1];

`ifdef NWR_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic [1:0]  err_q, err_d;
    logic        tmo_hit;

    // Fires on the TIMEOUT_CYC-th WAIT_DONE cycle.
    assign tmo_hit        = ({1'b0, tmo_cnt_q} + 17'd1) == 17'(TIMEOUT_CYC);
    assign bus.req0_err_o = err_q[0];
    assign bus.req1_err_o = err_q[1];
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYC;
    assign bus.req0_err_o = 1'b0;
    assign bus.req1_err_o = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        gnt_d        = gnt_q;
        user_addr_d  = user_addr_q;
        user_tsize_d = user_tsize_q;
        done_d       = '0;
        beat_cnt_d   = beat_cnt_q;
`ifdef NWR_ARB_TIMEOUT_EN
        err_d        = '0;
        tmo_cnt_d    = tmo_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if ((bus.req0_i | bus.req1_i) & bus.nwr_ready_in & ~bus.nwr_busy_in) begin
                    state_d = GRANT;
                    gnt_d   = win;
                    last_d  = win;
                end
            end
            GRANT: begin
                user_addr_d  = gnt_q ? bus.req1_addr_i  : bus.req0_addr_i;
                user_tsize_d = gnt_q ? bus.req1_tsize_i : bus.req0_tsize_i;
                beat_cnt_d   = '0;
                state_d      = XFER;
            end
            XFER: begin
                if (beat_acc && (beat_cnt_q != '1)) begin
                    beat_cnt_d = beat_cnt_q + 9'd1;
                end
                if (beat_acc & sel_tlast) begin
                    state_d = WAIT_DONE;
`ifdef NWR_ARB_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            WAIT_DONE: begin
                // Completion takes priority over a coincident timeout.
                if (bus.nwr_done_in) begin
                    state_d       = IDLE;
                    done_d[gnt_q] = 1'b1;
                end
`ifdef NWR_ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d      = IDLE;
                    err_d[gnt_q] = 1'b1;
                end
                tmo_cnt_d = tmo_cnt_q + 16'd1;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge log_clk or posedge log_rst) begin
        if (log_rst) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            gnt_q        <= 1'b0;
            user_addr_q  <= '0;
            user_tsize_q <= '0;
            done_q       <= '0;
            beat_cnt_q   <= '0;
`ifdef NWR_ARB_TIMEOUT_EN
            err_q        <= '0;
            tmo_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            gnt_q        <= gnt_d;
            user_addr_q  <= user_addr_d;
            user_tsize_q <= user_tsize_d;
            done_q       <= done_d;
            beat_cnt_q   <= beat_cnt_d;
`ifdef NWR_ARB_TIMEOUT_EN
            err_q        <= err_d;
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_nwr_arbiter.sv
// Directed/randomized bench for nwr_arbiter: requester streams, initiator status and
// a transaction-level scoreboard with a round-robin grant model.
module tb_nwr_arbiter;
    localparam int TMO  = 8;
    localparam int MAXB = 600;

    logic log_clk = 1'b0;
    logic log_rst = 1'b0;
    always #5 log_clk = ~log_clk;

    nwr_arbiter_if bus ();
    nwr_arbiter #(.TIMEOUT_CYC(TMO)) dut (
        .log_clk (log_clk),
        .log_rst (log_rst),
        .bus     (bus.master)
    );

    int          checks = 0;
    int          errors = 0;
    logic [72:0] beats [2][MAXB];   // {tlast, tkeep, tdata}
    int          len [2];
    int          idx [2];
    logic [33:0] src_addr [2];
    logic [11:0] src_tsize [2];
    logic [33:0] last_addr = '0;
    logic [72:0] fwd_q [$];
    int          rdy_mode = 0;      // 0: always ready, 1: toggle, 2: random
    bit          acc [2];
    bit          obs_tr [2];
    bit          done_s [2];
    bit          err_s [2];
    int          last_model = 1;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Round-robin reference: tie goes to whoever did not win last time.
    function automatic int pick(input bit r0, input bit r1);
        int w;
        if (r0 && r1) w = 1 - last_model;
        else          w = r1 ? 1 : 0;
        last_model = w;
        return w;
    endfunction

    task automatic set_req(input int n, input bit v);
        if (n == 0) bus.req0_i = v;
        else        bus.req1_i = v;
    endtask

    task automatic drive_src(input int n);
        logic        v;
        logic [72:0] b;
        v = idx[n] < len[n];
        b = v ? beats[n][idx[n]] : '0;
        if (n == 0) begin
            bus.req0_tvalid_i = v;
            bus.req0_tdata_i  = b[63:0];
            bus.req0_tkeep_i  = b[71:64];
            bus.req0_tlast_i  = b[72];
        end else begin
            bus.req1_tvalid_i = v;
            bus.req1_tdata_i  = b[63:0];
            bus.req1_tkeep_i  = b[71:64];
            bus.req1_tlast_i  = b[72];
        end
    endtask

    task automatic load(input int n, input int nb, input logic [33:0] addr, input logic [11:0] tsize);
        for (int i = 0; i < nb; i++)
            beats[n][i] = {1'(i == nb - 1), 8'($urandom), 32'($urandom), 32'($urandom)};
        len[n] = nb;
        idx[n] = 0;
        src_addr[n]  = addr;
        src_tsize[n] = tsize;
        if (n == 0) begin bus.req0_addr_i = addr; bus.req0_tsize_i = tsize; end
        else        begin bus.req1_addr_i = addr; bus.req1_tsize_i = tsize; end
        set_req(n, 1'b1);
        drive_src(n);
    endtask

    function automatic logic [33:0] rnd_addr();
        return {2'($urandom_range(0, 3)), 32'($urandom)};
    endfunction

    // Observe at negedge, then advance sources and tready just after the next posedge.
    task automatic tick();
        @(negedge log_clk);
        obs_tr[0] = bus.req0_tready_o;
        obs_tr[1] = bus.req1_tready_o;
        acc[0]    = bus.req0_tready_o && bus.req0_tvalid_i;
        acc[1]    = bus.req1_tready_o && bus.req1_tvalid_i;
        if (bus.user_tvalid_o && bus.user_tready_in)
            fwd_q.push_back({bus.user_tlast_o, bus.user_tkeep_o, bus.user_tdata_o});
        done_s[0] = bus.req0_done_o;
        done_s[1] = bus.req1_done_o;
        err_s[0]  = bus.req0_err_o;
        err_s[1]  = bus.req1_err_o;
        @(posedge log_clk);
        #1;
        for (int n = 0; n < 2; n++)
            if (acc[n]) begin
                idx[n]++;
                drive_src(n);
            end
        case (rdy_mode)
            0:       bus.user_tready_in = 1'b1;
            1:       bus.user_tready_in = ~bus.user_tready_in;
            default: bus.user_tready_in = 1'($urandom_range(0, 1));
        endcase
    endtask

    // kind 0: nwr_done_in d cycles into WAIT_DONE; 1: expect timeout err; 2: expect no completion.
    task automatic run_txn(input string tag, input int w, input int d, input int kind,
                           input int rearm, input bit drop, input int max_cyc);
        int cd, since, lat, dp, ep, wrong, viol, nb, post, nbad;
        bit tl_seen, fin, dropped;
        fwd_q.delete();
        cd = -1; since = 0; lat = -1; dp = 0; ep = 0; wrong = 0; viol = 0;
        nb = 0; post = 0; tl_seen = 0; fin = 0; dropped = 0;
        for (int c = 0; c < max_cyc && post < 1; c++) begin
            tick();
            if (tl_seen) since++;
            if (obs_tr[1-w]) viol++;
            if (done_s[w]) dp++;
            if (err_s[w]) ep++;
            if (done_s[1-w] || err_s[1-w]) wrong++;
            if (fin) post++;
            else if (done_s[w] || err_s[w]) begin
                fin = 1'b1;
                lat = since;
            end
            if (drop && !dropped && acc[w]) begin
                set_req(w, 1'b0);
                dropped = 1'b1;
            end
            if (acc[w] && idx[w] == len[w] && !tl_seen) begin
                tl_seen = 1'b1;
                nb      = len[w];
                nbad    = 0;
                for (int i = 0; i < nb && i < fwd_q.size(); i++)
                    if (fwd_q[i] !== beats[w][i]) nbad++;
                chk({tag, ":beats"}, fwd_q.size(), nb);
                chk({tag, ":data_bad"}, nbad, 0);
                chk({tag, ":addr"}, bus.user_addr_o, src_addr[w]);
                chk({tag, ":tsize"}, bus.user_tsize_o, src_tsize[w]);
                chk({tag, ":beat_cnt"}, dut.beat_cnt_q, (nb > 511) ? 511 : nb);
                last_addr = src_addr[w];
                if (kind == 0) cd = d;
                if (rearm > 0) load(w, rearm, rnd_addr(), 12'($urandom));
                else           set_req(w, 1'b0);
            end
            if (cd == 0) begin
                bus.nwr_done_in = 1'b1;
                cd = -1;
            end else begin
                bus.nwr_done_in = 1'b0;
                if (cd > 0) cd--;
            end
        end
        bus.nwr_done_in = 1'b0;
        chk({tag, ":tlast_seen"}, tl_seen, 1);
        chk({tag, ":fwd_total"}, fwd_q.size(), nb);
        chk({tag, ":other_pulse"}, wrong, 0);
        chk({tag, ":nongrant_tready"}, viol, 0);
        case (kind)
            0: begin
                chk({tag, ":done_pulses"}, dp, 1);
                chk({tag, ":err_pulses"}, ep, 0);
                chk({tag, ":done_latency"}, lat, d + 2);
            end
            1: begin
                chk({tag, ":err_pulses"}, ep, 1);
                chk({tag, ":done_pulses"}, dp, 0);
                chk({tag, ":err_latency"}, lat, TMO + 1);
            end
            default: begin
                chk({tag, ":done_pulses"}, dp, 0);
                chk({tag, ":err_pulses"}, ep, 0);
            end
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int pulses;
        int tr_seen;
        logic [33:0] busy_addr;

        bus.req0_i = 0; bus.req1_i = 0;
        bus.req0_addr_i = '0; bus.req1_addr_i = '0;
        bus.req0_tsize_i = '0; bus.req1_tsize_i = '0;
        bus.nwr_ready_in = 1'b1; bus.nwr_busy_in = 1'b0; bus.nwr_done_in = 1'b0;
        bus.user_tready_in = 1'b1;
        drive_src(0);
        drive_src(1);
        #1 log_rst = 1'b1;
        repeat (3) @(posedge log_clk);
        @(negedge log_clk);
        chk("rst:addr", bus.user_addr_o, 0);
        chk("rst:tsize", bus.user_tsize_o, 0);
        chk("rst:tvalid", bus.user_tvalid_o, 0);
        chk("rst:tlast", bus.user_tlast_o, 0);
        chk("rst:tready", {bus.req1_tready_o, bus.req0_tready_o}, 0);
        chk("rst:done", {bus.req1_done_o, bus.req0_done_o}, 0);
        chk("rst:err", {bus.req1_err_o, bus.req0_err_o}, 0);
        log_rst = 1'b0;

        // Both requesting continuously: grant order 0,1,0 then drain requester 1.
        rdy_mode = 2;
        load(0, 5, rnd_addr(), 12'd39);
        load(1, 7, rnd_addr(), 12'd55);
        w = pick(bus.req0_i, bus.req1_i);
        run_txn("tie1", w, 1, 0, 6, 0, 200);
        w = pick(bus.req0_i, bus.req1_i);
        run_txn("tie2", w, 0, 0, 4, 0, 200);
        w = pick(bus.req0_i, bus.req1_i);
        run_txn("tie3", w, 2, 0, 0, 0, 200);
        w = pick(bus.req0_i, bus.req1_i);
        run_txn("tie4", w, 0, 0, 0, 0, 200);

        // Single requester, 16 beats, fixed address and size.
        rdy_mode = 0;
        load(0, 16, 34'h1_0000_0000, 12'd127);
        w = pick(bus.req0_i, bus.req1_i);
        run_txn("single16", w, 3, 0, 0, 0, 200);

        // Toggling tready across a 33-beat transfer.
        rdy_mode = 1;
        load(1, 33, rnd_addr(), 12'd263);
        w = pick(bus.req0_i, bus.req1_i);
        run_txn("toggle33", w, 0, 0, 0, 0, 400);

        // Request withdrawn after the first beat still completes.
        rdy_mode = 2;
        load(0, 10, rnd_addr(), 12'd79);
        w = pick(bus.req0_i, bus.req1_i);
        run_txn("drop_req", w, 4, 0, 0, 1, 400);

        // Long transfer saturates the beat counter.
        load(1, 515, rnd_addr(), 12'hFFF);
        w = pick(bus.req0_i, bus.req1_i);
        run_txn("sat515", w, 0, 0, 0, 0, 4000);

        // Busy initiator holds the request off; grant follows release by one cycle.
        rdy_mode = 0;
        bus.nwr_busy_in = 1'b1;
        busy_addr = rnd_addr();
        load(1, 4, busy_addr, 12'd31);
        tr_seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (obs_tr[0] || obs_tr[1]) tr_seen++;
        end
        chk("busy:tready_seen", tr_seen, 0);
        chk("busy:addr_held", bus.user_addr_o, last_addr);
        bus.nwr_busy_in = 1'b0;
        tick();
        chk("busy:addr_in_grant", bus.user_addr_o, last_addr);
        tick();
        chk("busy:addr_after_grant", bus.user_addr_o, busy_addr);
        w = pick(bus.req0_i, bus.req1_i);
        run_txn("busy_rel", w, 1, 0, 0, 0, 200);

        // nwr_done_in while idle must not produce a pulse.
        bus.nwr_done_in = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.nwr_done_in = 1'b0;
            if (done_s[0] || done_s[1] || err_s[0] || err_s[1]) pulses++;
        end
        chk("idle_done:pulses", pulses, 0);

`ifdef NWR_ARB_TIMEOUT_EN
        load(0, 3, rnd_addr(), 12'd23);
        w = pick(bus.req0_i, bus.req1_i);
        run_txn("timeout", w, 0, 1, 0, 0, 200);
        load(1, 2, rnd_addr(), 12'd15);
        w = pick(bus.req0_i, bus.req1_i);
        run_txn("done_at_expiry", w, TMO - 1, 0, 0, 0, 200);
`else
        load(0, 3, rnd_addr(), 12'd23);
        w = pick(bus.req0_i, bus.req1_i);
        run_txn("no_timeout", w, 0, 2, 0, 0, 60);
        bus.nwr_done_in = 1'b1;
        tick();
        bus.nwr_done_in = 1'b0;
        tick();
        chk("late_done:pulse", done_s[0], 1);
        chk("late_done:err", err_s[0], 0);
`endif

        // Reset in the middle of a transfer.
        rdy_mode = 0;
        load(0, 40, rnd_addr(), 12'd319);
        w = pick(bus.req0_i, bus.req1_i);
        for (int c = 0; c < 100 && idx[0] < 5; c++) tick();
        chk("mid_rst:beats_before", idx[0], 5);
        log_rst = 1'b1;
        #2;
        chk("mid_rst:addr", bus.user_addr_o, 0);
        chk("mid_rst:tsize", bus.user_tsize_o, 0);
        chk("mid_rst:tvalid", bus.user_tvalid_o, 0);
        chk("mid_rst:tlast", bus.user_tlast_o, 0);
        chk("mid_rst:tready", {bus.req1_tready_o, bus.req0_tready_o}, 0);
        set_req(0, 1'b0);
        len[0] = 0;
        idx[0] = 0;
        drive_src(0);
        last_model = 1;
        pulses = 0;
        tick();
        tick();
        if (done_s[0] || done_s[1] || err_s[0] || err_s[1]) pulses++;
        log_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done_s[0] || done_s[1] || err_s[0] || err_s[1]) pulses++;
        end
        chk("mid_rst:pulses", pulses, 0);
        load(1, 4, rnd_addr(), 12'd31);
        w = pick(bus.req0_i, bus.req1_i);
        run_txn("after_rst", w, 2, 0, 0, 0, 200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/nwr_arbiter.md
NWR_ARBITER -- requirements
Module: nwr_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYC, 1023, number of log_clk cycles allowed in WAIT_DONE before abort (range 1..65535).
REQ-002 log_clk  in  1  clock; all logic on rising edge.
REQ-003 log_rst  in  1  reset, asynchronous, active-high.
REQ-004 reqN_i (N=0,1)  in  1  requester N has a pending NWRITE.
REQ-005 reqN_addr_i  in  34  target address, sampled at grant.
REQ-006 reqN_tsize_i  in  12  byte count minus one, sampled at grant.
REQ-007 reqN_tdata_i / reqN_tkeep_i / reqN_tvalid_i / reqN_tlast_i  in  64/8/1/1  requester N payload stream.
REQ-008 reqN_tready_o  out  1  payload accepted from requester N.
REQ-009 reqN_done_o  out  1  one-cycle pulse, requester N transaction completed.
REQ-010 reqN_err_o  out  1  one-cycle pulse, requester N transaction timed out.
REQ-011 nwr_ready_in / nwr_busy_in / nwr_done_in  in  1 each  NWRITE initiator status.
REQ-012 user_tready_in  in  1  initiator accepts payload beat.
REQ-013 user_addr_o / user_tsize_o  out  34/12  registered address and size of the granted transaction.
REQ-014 user_tdata_o / user_tkeep_o / user_tvalid_o / user_tlast_o  out  64/8/1/1  muxed payload to initiator.

Function
REQ-015 FSM states IDLE, GRANT, XFER, WAIT_DONE; encoding 2 bits.
REQ-016 IDLE->GRANT when (req0_i|req1_i) & nwr_ready_in & !nwr_busy_in; else stay.
REQ-017 Arbitration round-robin: single request wins; both requesting -> the requester not granted last wins; last-grant pointer resets to 1 so requester 0 wins first tie.
REQ-018 GRANT: one cycle; register winner's addr/tsize into user_addr_o/user_tsize_o; next state XFER.
REQ-019 XFER: user_tdata/tkeep/tvalid/tlast_o equal granted requester's inputs combinationally; granted reqN_tready_o = user_tready_in; non-granted tready_o = 0.
REQ-020 Outside XFER: user_tvalid_o = 0, user_tlast_o = 0, all reqN_tready_o = 0.
REQ-021 XFER->WAIT_DONE on the cycle user_tvalid_o & user_tready_in & user_tlast_o; no beat after tlast is forwarded.
REQ-022 WAIT_DONE->IDLE on nwr_done_in; granted reqN_done_o pulses that same cycle edge (registered, asserted the following cycle for exactly one cycle).
REQ-023 nwr_done_in outside WAIT_DONE is ignored.
REQ-024 Deassertion of reqN_i after GRANT does not abort; transaction finishes on tlast.
REQ-025 Beat counter (9 bits) counts accepted beats in XFER; saturates at 511; cleared in GRANT; observable only in verification hooks.
REQ-026 Back-to-back: from IDLE a new grant can follow one cycle after WAIT_DONE exit; minimum 4 cycles between successive GRANT states when payload is one beat.

Reset
REQ-027 On log_rst: state IDLE, pointer 1, user_addr_o 0, user_tsize_o 0, all done/err pulses 0, timeout counter 0.
REQ-028 Reset asserted mid-XFER or mid-WAIT_DONE drops the transaction immediately; no done or err pulse is issued.

Configuration
REQ-029 Macro NWR_ARB_TIMEOUT_EN defined: 16-bit counter cleared on entry to WAIT_DONE, increments each WAIT_DONE cycle; reaching TIMEOUT_CYC without nwr_done_in -> IDLE and granted reqN_err_o pulses one cycle; nwr_done_in on the same cycle as expiry wins (done, no err).
REQ-030 Macro undefined: no counter logic; WAIT_DONE waits indefinitely; reqN_err_o tied 0.

Verification
REQ-031 req0 alone, addr 0x1_0000_0000, tsize 127, 16 beats, tready constant 1 -> user_addr_o=0x100000000, user_tsize_o=127, 16 beats, tlast on beat 16, req0_done_o one pulse after nwr_done_in.
REQ-032 req0 and req1 asserted together for three transactions -> grant order 0,1,0; non-granted tready_o stays 0 throughout.
REQ-033 tready toggling 1/0 every cycle during 33-beat transfer -> all 33 beats forwarded in order, none duplicated, beat counter = 33.
REQ-034 nwr_busy_in=1 with req1 pending -> stays IDLE; busy drops -> GRANT next cycle.
REQ-035 With NWR_ARB_TIMEOUT_EN, TIMEOUT_CYC=8, no nwr_done_in -> err pulse after 8 WAIT_DONE cycles, back in IDLE; without macro -> remains WAIT_DONE.
REQ-036 log_rst pulsed at beat 5 of XFER -> all outputs at reset values, no done/err, next request granted normally.
